note_sequencer: RTL

Parametrised multi-voice successor to the single-voice SRAM music player. Fetches 16-bit instructions from external SRAM, decodes notes, tempo changes and end markers, and drives up to 4 independent tone voices with per-voice duration, volume and release gap. Tempo changes are computed at run time by a sequential divider instead of a fixed BPM. Sits between the SRAM pins and the speaker/LED pins at top level.

---
 rtl/note_seq_pkg.sv | 36 +++
 rtl/seq_divider.sv | 46 ++++
 rtl/note_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared opcodes, sequencer states, instruction fields and the
// 50 MHz base pitch table for the multi-voice note sequencer.
package note_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_HOLD,
        S_DIV,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_END = 4'h0;
    localparam logic [3:0] OP_BPM = 4'h1;

    localparam int F_NOTE  = 15;
    localparam int F_CHORD = 14;
    localparam int F_VOICE = 12;
    localparam int F_LEN   = 8;
    localparam int F_VOL   = 6;
    localparam int F_OCT   = 4;

    // Octave-4 periods in clock cycles at 50 MHz, C4..B4
    localparam logic [17:0] BASE_PERIOD [12] = '{
        18'd191110, 18'd180388, 18'd170265, 18'd160705,
        18'd151685, 18'd143172, 18'd135139, 18'd127551,
        18'd120395, 18'd113636, 18'd107259, 18'd101238
    };

    function automatic logic [17:0] base_period(input logic [3:0] n);
        return (n < 4'd12) ? BASE_PERIOD[n] : 18'd0;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring 32/12-bit unsigned divider, one load cycle then
// 32 shift/subtract iterations; done pulses with the quotient valid.
module seq_divider (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [11:0] divisor,
    output logic        done,
    output logic [31:0] quotient
);

    logic [11:0] rem;
    logic [5:0]  cnt;
    logic        busy;
    logic [12:0] trial;
    logic        fits;

    assign trial = {rem, quotient[31]};
    assign fits  = trial >= {1'b0, divisor};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rem      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= '0;
                quotient <= dividend;
                cnt      <= 6'd32;
                busy     <= 1'b1;
            end else if (busy) begin
                rem      <= fits ? 12'(trial - {1'b0, divisor}) : trial[11:0];
                quotient <= {quotient[30:0], fits};
                cnt      <= cnt - 6'd1;
                busy     <= cnt != 6'd1;
                done     <= cnt == 6'd1;
            end
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: fetches 16-bit instructions from SRAM and plays them on up
// to four square-wave voices with run-time tempo via a sequential divider.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int VOICES      = 2,
    parameter int ADDR_W      = 18,
    parameter int SRAM_LAT    = 2,
    parameter int GAP_CYCLES  = 5_000_000,
    parameter int DEFAULT_BPM = 96
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    output logic [ADDR_W-1:0] SRAM_A,
    input  logic [15:0]       SRAM_D,
    output logic              SRAM_WE,
    output logic              SRAM_CE,
    output logic              SRAM_OE,
    output logic              SRAM_LB,
    output logic              SRAM_UB,
    output logic              SPEAKER,
    output logic [VOICES-1:0] VOICE_OUT,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] PC
);

    localparam logic [31:0] DIVIDEND     = 32'(longint'(CLK_HZ) * 60);
    localparam logic [31:0] DEFAULT_BEAT = 32'(longint'(CLK_HZ) * 60 / DEFAULT_BPM);
    localparam logic [31:0] GAP          = 32'(GAP_CYCLES);
    localparam logic [7:0]  LAT_M1       = 8'(SRAM_LAT - 1);
    localparam logic [2:0]  NV           = 3'(VOICES);
    localparam logic [1:0]  SEL_MAX      = 2'(VOICES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state, nstate;
    logic [ADDR_W-1:0] addr, pc;
    logic [15:0]       ir;
    logic [31:0]       beat, hold_cnt, note_cycles, div_q;
    logic [7:0]        lat_cnt;
    logic [1:0]        sel;
    logic [VOICES-1:0] active;
    logic              div_start, div_done, start_ok;

    logic [3:0]  opc, len, note;
    logic [1:0]  voice, vol, oct;
    logic [11:0] bpm;
    logic        is_note, chord, note_ok, is_end, is_bpm;
    logic [17:0] new_period, new_hi;

    assign opc     = ir[15:12];
    assign is_note = ir[F_NOTE];
    assign chord   = ir[F_CHORD];
    assign voice   = ir[F_VOICE+:2];
    assign len     = ir[F_LEN+:4];
    assign vol     = ir[F_VOL+:2];
    assign oct     = ir[F_OCT+:2];
    assign note    = ir[3:0];
    assign bpm     = ir[11:0];
    assign is_end  = opc == OP_END;
    assign is_bpm  = opc == OP_BPM;
    assign note_ok = is_note && ({1'b0, voice} < NV);

    assign note_cycles = (beat >> 2) * 32'({1'b0, len} + 5'd1);
    assign new_period  = base_period(note) >> oct;
    assign new_hi      = (new_period >> 4) * 18'({1'b0, vol} + 3'd1);

    assign start_ok  = START && (state == S_IDLE || state == S_HALT);
    assign div_start = state == S_DECODE && is_bpm && bpm != 12'd0;

    seq_divider u_div (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  (bpm),
        .done     (div_done),
        .quotient (div_q)
    );

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE, S_HALT: nstate = START ? S_FETCH : state;
            S_FETCH:        nstate = S_WAIT;
            S_WAIT:         nstate = (lat_cnt == '0) ? S_DECODE : S_WAIT;
            S_DECODE:       nstate = is_end ? S_HALT :
                                     div_start ? S_DIV :
                                     (note_ok && !chord && note_cycles > 32'd1) ? S_HOLD : S_FETCH;
            S_HOLD:         nstate = (hold_cnt <= 32'd1) ? S_FETCH : S_HOLD;
            S_DIV:          nstate = div_done ? S_FETCH : S_DIV;
            default:        nstate = S_IDLE;
        endcase
    end

    // HOLD is entered with noteCycles-1 so the next FETCH lands at DECODE+noteCycles
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            addr     <= '0;
            pc       <= '0;
            ir       <= '0;
            beat     <= DEFAULT_BEAT;
            hold_cnt <= '0;
            lat_cnt  <= '0;
            sel      <= '0;
        end else begin
            state <= nstate;
            sel   <= (sel == SEL_MAX) ? 2'd0 : sel + 2'd1;
            if (start_ok) begin
                addr <= '0;
                beat <= DEFAULT_BEAT;
            end
            if (state == S_FETCH) lat_cnt <= LAT_M1;
            if (state == S_WAIT) begin
                lat_cnt <= lat_cnt - 8'd1;
                if (lat_cnt == '0) begin
                    ir   <= SRAM_D;
                    pc   <= addr;
                    addr <= addr + ADDR_ONE;
                end
            end
            if (state == S_DECODE) hold_cnt <= note_cycles - 32'd1;
            if (state == S_HOLD) hold_cnt <= hold_cnt - 32'd1;
            if (state == S_DIV && div_done) beat <= div_q;
        end
    end

    for (genvar i = 0; i < VOICES; i++) begin : g_voice
        logic [31:0] rem;
        logic [17:0] phase, period, hi;
        logic        silent, trig;

        assign trig = state == S_DECODE && note_ok && voice == 2'(i);

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                rem    <= '0;
                phase  <= '0;
                period <= '0;
                hi     <= '0;
                silent <= 1'b1;
            end else if (trig) begin
                rem    <= note_cycles;
                phase  <= '0;
                period <= new_period;
                hi     <= new_hi;
                silent <= note >= 4'd12;
            end else begin
                rem   <= (rem != '0) ? rem - 32'd1 : rem;
                phase <= (phase >= period - 18'd1) ? 18'd0 : phase + 18'd1;
            end
        end

        // Audible only while more than GAP cycles of the note remain
        assign VOICE_OUT[i] = !silent && rem > GAP && phase < hi;
        assign active[i]    = rem != '0;
    end

    always_comb begin
        SPEAKER = 1'b0;
        for (int k = 0; k < VOICES; k++)
            if (sel == 2'(k)) SPEAKER = VOICE_OUT[k];
    end

    assign SRAM_A  = addr;
    assign PC      = pc;
    assign BUSY    = !(state == S_IDLE || state == S_HALT);
    assign DONE    = state == S_HALT && active == '0;
    assign SRAM_WE = 1'b1;
    assign SRAM_CE = 1'b0;
    assign SRAM_OE = 1'b0;
    assign SRAM_LB = 1'b0;
    assign SRAM_UB = 1'b0;

endmodule
